mem_arb: RTL and testbench

Two-port arbiter that shares the core's single data/instruction memory between the instruction-fetch path (IF) and the load/store path (LS). It accepts one request per access, drives the memory port with registered signals, waits for `mem_ready`, and returns a one-cycle completion pulse with read data to the winning requester. It sits between `pc_reg`/ctrl/wb and the memory. It is the first step away from the combinational dual-read memory towards a multi-cycle, single-port memory.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_if.sv | 48 ++++
 rtl/mem_arb_starve_cnt.sv | 40 ++++
 rtl/mem_arb.sv | 145 ++++++++++++++
 tb/tb_mem_arb.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS memory arbiter: FSM state encoding, access-size codes
// and the starvation-counter width helper.
package mem_arb_pkg;

  localparam int ARB_STATE_WIDTH = 2;

  typedef enum logic [ARB_STATE_WIDTH-1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IF_BUSY = 2'd1,
    ARB_LS_BUSY = 2'd2
  } arb_state_e;

  localparam int CPU_WIDTH_DEF  = 32;
  localparam int SIZE_WIDTH_DEF = 2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of requester (IF, LS) and single-port memory signals around mem_arb.
// slave = the arbiter's view; master = the core/memory side that drives it.
interface mem_arb_if #(
  parameter int CPU_WIDTH  = 32,
  parameter int SIZE_WIDTH = 2
);
  logic                  if_req;
  logic [CPU_WIDTH-1:0]  if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [CPU_WIDTH-1:0]  if_rdata;

  logic                  ls_req;
  logic                  ls_we;
  logic [SIZE_WIDTH-1:0] ls_size;
  logic [CPU_WIDTH-1:0]  ls_addr;
  logic [CPU_WIDTH-1:0]  ls_wdata;
  logic                  ls_gnt;
  logic                  ls_rvalid;
  logic [CPU_WIDTH-1:0]  ls_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [SIZE_WIDTH-1:0] mem_size;
  logic [CPU_WIDTH-1:0]  mem_addr;
  logic [CPU_WIDTH-1:0]  mem_wdata;
  logic [CPU_WIDTH-1:0]  mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    input  mem_rdata, mem_ready,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_size, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    output mem_rdata, mem_ready,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_size, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of LS grants won while IF was waiting; force_if_o asks the
// arbiter to let IF win once the count reaches STARVE_MAX. Cleared by any IF grant.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_i,
  input  logic if_gnt_i,
  input  logic ls_gnt_i,
  output logic force_if_o
);

  localparam int CW = cnt_width(STARVE_MAX);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (if_gnt_i) begin
      cnt_d = '0;
    end else if (ls_gnt_i && if_req_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_if_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arb.sv
// Shares one single-port memory between instruction fetch and load/store; LS has
// priority unless MEM_ARB_STARVE_EN is defined, which bounds IF starvation.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int CPU_WIDTH  = CPU_WIDTH_DEF,
  parameter int SIZE_WIDTH = SIZE_WIDTH_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic     clk,
  input  logic     rst,
  mem_arb_if.slave arb_if
);

  arb_state_e state_q, state_d;

  logic                  mem_en_q,    mem_en_d;
  logic                  mem_we_q,    mem_we_d;
  logic [SIZE_WIDTH-1:0] mem_size_q,  mem_size_d;
  logic [CPU_WIDTH-1:0]  mem_addr_q,  mem_addr_d;
  logic [CPU_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  ls_rvalid_q, ls_rvalid_d;
  logic [CPU_WIDTH-1:0]  if_rdata_q,  if_rdata_d;
  logic [CPU_WIDTH-1:0]  ls_rdata_q,  ls_rdata_d;

  logic if_gnt, ls_gnt, force_if;

`ifdef MEM_ARB_STARVE_EN
  mem_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (arb_if.if_req),
    .if_gnt_i   (if_gnt),
    .ls_gnt_i   (ls_gnt),
    .force_if_o (force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        mem_en_d = 1'b0;
        // Grants are masked during reset so no requester believes it was served.
        if (!rst) begin
          if (arb_if.ls_req && !(force_if && arb_if.if_req)) begin
            ls_gnt = 1'b1;
          end else if (arb_if.if_req) begin
            if_gnt = 1'b1;
          end
        end
        if (ls_gnt) begin
          state_d     = ARB_LS_BUSY;
          mem_en_d    = 1'b1;
          mem_we_d    = arb_if.ls_we;
          mem_size_d  = arb_if.ls_size;
          mem_addr_d  = arb_if.ls_addr;
          mem_wdata_d = arb_if.ls_wdata;
        end else if (if_gnt) begin
          state_d     = ARB_IF_BUSY;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_size_d  = SIZE_WIDTH'(SIZE_WORD);
          mem_addr_d  = arb_if.if_addr;
        end
      end
      ARB_IF_BUSY: begin
        if (arb_if.mem_ready) begin
          state_d     = ARB_IDLE;
          mem_en_d    = 1'b0;
          if_rdata_d  = arb_if.mem_rdata;
          if_rvalid_d = 1'b1;
        end
      end
      ARB_LS_BUSY: begin
        if (arb_if.mem_ready) begin
          state_d     = ARB_IDLE;
          mem_en_d    = 1'b0;
          ls_rdata_d  = arb_if.mem_rdata;
          ls_rvalid_d = 1'b1;
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        mem_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign arb_if.if_gnt    = if_gnt;
  assign arb_if.ls_gnt    = ls_gnt;
  assign arb_if.if_rvalid = if_rvalid_q;
  assign arb_if.ls_rvalid = ls_rvalid_q;
  assign arb_if.if_rdata  = if_rdata_q;
  assign arb_if.ls_rdata  = ls_rdata_q;
  assign arb_if.mem_en    = mem_en_q;
  assign arb_if.mem_we    = mem_we_q;
  assign arb_if.mem_size  = mem_size_q;
  assign arb_if.mem_addr  = mem_addr_q;
  assign arb_if.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Random IF/LS traffic against a 16-word memory; a transaction-level model predicts
// grants, memory-port contents and completions, and a monitor checks returned data.
module tb_mem_arb;

  localparam int W    = 32;
  localparam int SW   = 2;
  localparam int SMAX = 4;
  localparam int NCYC = 4000;
  localparam logic [SW-1:0] WORD = 2'b10;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  typedef struct packed {
    logic         is_ls;
    logic         is_load;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arb_if #(.CPU_WIDTH(W), .SIZE_WIDTH(SW)) bus ();

  mem_arb #(.CPU_WIDTH(W), .SIZE_WIDTH(SW), .STARVE_MAX(SMAX)) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (bus)
  );

  logic [W-1:0] tb_mem  [16];
  logic [W-1:0] ref_mem [16];
  exp_t         sb_q[$];
  int           n_chk  = 0;
  int           n_pass = 0;

  function automatic logic [W-1:0] seed(input int i);
    return (32'h1357_9BDF * (i + 1)) ^ 32'h5A5A_A5A5;
  endfunction

  assign bus.mem_rdata = tb_mem[bus.mem_addr[5:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= seed(i);
    end else if (bus.mem_en && bus.mem_we && bus.mem_ready) begin
      tb_mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end
  end

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Model state: who owns the memory and what it asked for.
  int           owner = 0;  // 0 none, 1 IF, 2 LS
  logic         t_we;
  logic [SW-1:0] t_size;
  logic [W-1:0] t_addr, t_wdata;
  logic         exp_if_rv = 1'b0, exp_ls_rv = 1'b0;
  logic         just_rst  = 1'b1;
  int           starve    = 0;
  logic         got_if = 1'b0, got_ls = 1'b0;

  task automatic model_step();
    logic e_if_gnt, e_ls_gnt, force_if;
    logic [W-1:0] d;
    e_if_gnt = 1'b0;
    e_ls_gnt = 1'b0;
    force_if = STARVE_ON && (starve == SMAX) && bus.if_req;
    if (!rst && owner == 0) begin
      if (bus.ls_req && !force_if) e_ls_gnt = 1'b1;
      else if (bus.if_req)         e_if_gnt = 1'b1;
    end
    chk1("if_gnt", bus.if_gnt, e_if_gnt);
    chk1("ls_gnt", bus.ls_gnt, e_ls_gnt);
    chk1("if_rvalid", bus.if_rvalid, exp_if_rv);
    chk1("ls_rvalid", bus.ls_rvalid, exp_ls_rv);
    chk1("mem_en", bus.mem_en, owner != 0);
    if (owner != 0) begin
      chkw("mem_addr", bus.mem_addr, t_addr);
      chk1("mem_we", bus.mem_we, t_we);
      chkw("mem_size", W'(bus.mem_size), W'(t_size));
      if (t_we) chkw("mem_wdata", bus.mem_wdata, t_wdata);
    end
    if (just_rst) begin
      chkw("rst_mem_addr", bus.mem_addr, '0);
      chk1("rst_mem_we", bus.mem_we, 1'b0);
      chkw("rst_mem_size", W'(bus.mem_size), '0);
      chkw("rst_mem_wdata", bus.mem_wdata, '0);
      chkw("rst_if_rdata", bus.if_rdata, '0);
      chkw("rst_ls_rdata", bus.ls_rdata, '0);
    end
    got_if    = bus.if_gnt;
    got_ls    = bus.ls_gnt;
    exp_if_rv = 1'b0;
    exp_ls_rv = 1'b0;
    just_rst  = rst;
    if (rst) begin
      owner  = 0;
      starve = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = seed(i);
    end else if (owner != 0) begin
      if (bus.mem_ready) begin
        d = ref_mem[t_addr[5:2]];
        if (owner == 2 && t_we) ref_mem[t_addr[5:2]] = t_wdata;
        sb_q.push_back('{is_ls: (owner == 2), is_load: !(owner == 2 && t_we), data: d});
        if (owner == 1) exp_if_rv = 1'b1;
        else            exp_ls_rv = 1'b1;
        owner = 0;
      end
    end else if (e_ls_gnt) begin
      owner   = 2;
      t_we    = bus.ls_we;
      t_size  = bus.ls_size;
      t_addr  = bus.ls_addr;
      t_wdata = bus.ls_wdata;
      if (bus.if_req && starve < SMAX) starve++;
    end else if (e_if_gnt) begin
      owner  = 1;
      t_we   = 1'b0;
      t_size = WORD;
      t_addr = bus.if_addr;
      starve = 0;
    end
  endtask

  // Completion monitor: pairs each rvalid pulse with the oldest predicted access.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.if_rvalid || bus.ls_rvalid) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_underflow: rvalid if=%b ls=%b with no access pending at %0t",
                   bus.if_rvalid, bus.ls_rvalid, $time);
        end else begin
          e = sb_q.pop_front();
          chk1("rv_owner", bus.ls_rvalid, e.is_ls);
          if (!e.is_ls)      chkw("if_rdata", bus.if_rdata, e.data);
          else if (e.is_load) chkw("ls_rdata", bus.ls_rdata, e.data);
        end
      end
    end
  end

  initial begin
    int mode;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = '0;
    bus.ls_addr = '0;  bus.ls_wdata = '0;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = seed(i);

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      mode = (c / 400) % 2;
      rst  = (c < 3) || ($urandom_range(0, 149) == 0);
      bus.if_addr  = $urandom;
      bus.ls_addr  = $urandom;
      bus.ls_wdata = $urandom;
      bus.ls_we    = 1'($urandom_range(0, 1));
      bus.ls_size  = SW'($urandom_range(0, 3));
      if (mode == 1) begin
        bus.if_req    = 1'b1;
        bus.ls_req    = 1'b1;
        bus.mem_ready = 1'b1;
      end else begin
        bus.mem_ready = ($urandom_range(0, 2) != 0);
        if (bus.if_req && !got_if) begin
          if ($urandom_range(0, 31) == 0) bus.if_req = 1'b0;
        end else begin
          bus.if_req = ($urandom_range(0, 2) == 0);
        end
        if (bus.ls_req && !got_ls) begin
          if ($urandom_range(0, 31) == 0) bus.ls_req = 1'b0;
        end else begin
          bus.ls_req = ($urandom_range(0, 2) == 0);
        end
      end
      @(negedge clk);
      model_step();
    end

    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      model_step();
    end
    chkw("sb_drained", W'(sb_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
